ether_tx_arbiter: RTL and testbench

Shares the single GMII transmit path (phy_tx_en/er/data toward the PHY) between two frame sources, such as the UDP demo transmitter and a future ARP/ICMP responder. It uses request/grant handshaking with round-robin priority. It enforces a minimum inter-frame gap and guards against oversize frames and grants that the requester never uses. It sits between the frame generators and the Ethernet PHY pins, in the clk_125 domain produced by ether_timing.

---
 rtl/ether_pkg.sv | 23 ++
 rtl/ether_rr_select.sv | 20 ++
 rtl/ether_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ether_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ether_pkg.sv
// Shared Ethernet transmit definitions: arbiter state encoding, default limits
// and the GMII byte-lane payload type.
package ether_pkg;

    localparam int unsigned IFG_DEFAULT           = 12;
    localparam int unsigned MAX_LEN_DEFAULT       = 1526;
    localparam int unsigned START_TIMEOUT_DEFAULT = 64;
    localparam logic [7:0]  GMII_ERR_BYTE         = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_XMIT     = 2'd2,
        ST_IFG      = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] data;
    } gmii_t;

endpackage

// File: rtl/ether_rr_select.sv
// Combinational 2-way round-robin pick; prio names the winner on a tie.
module ether_rr_select (
    input  logic elig0,
    input  logic elig1,
    input  logic prio,
    output logic idx_c,
    output logic valid_c
);

    always_comb begin
        idx_c   = 1'b0;
        valid_c = elig0 | elig1;
        if (elig0 && elig1) begin
            idx_c = prio;
        end else if (elig1) begin
            idx_c = 1'b1;
        end
    end

endmodule

// File: rtl/ether_tx_arbiter.sv
// Two-source GMII transmit arbiter: round-robin grant, inter-frame gap,
// oversize truncation with error propagation and unused-grant timeout.
module ether_tx_arbiter
    import ether_pkg::*;
#(
    parameter int unsigned IFG_CYCLES    = IFG_DEFAULT,
    parameter int unsigned MAX_LEN       = MAX_LEN_DEFAULT,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic       clk_125,
    input  logic       rst,
    input  logic       req0,
    output logic       gnt0,
    input  logic       tx0_en,
    input  logic [7:0] tx0_data,
    input  logic       req1,
    output logic       gnt1,
    input  logic       tx1_en,
    input  logic [7:0] tx1_data,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic [7:0] phy_tx_data,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    localparam int unsigned TMR_W = $clog2(START_TIMEOUT);
    localparam int unsigned IFG_W = $clog2(IFG_CYCLES + 1);

    arb_state_t       state, state_d;
    logic             owner, owner_d;
    logic             prio, prio_d;
    logic             gnt0_d, gnt1_d;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic [IFG_W-1:0] ifg_cnt, ifg_cnt_d;
    gmii_t            phy, phy_d;

    logic             own_req, own_en;
    logic [7:0]       own_data;
    logic             pick_idx, pick_valid;

    assign own_req  = owner ? req1     : req0;
    assign own_en   = owner ? tx1_en   : tx0_en;
    assign own_data = owner ? tx1_data : tx0_data;

    // A source already driving en is not eligible, so no frame starts mid-stream.
    ether_rr_select u_rr_select (
        .elig0   (req0 & ~tx0_en),
        .elig1   (req1 & ~tx1_en),
        .prio    (prio),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        prio_d     = prio;
        gnt0_d     = gnt0;
        gnt1_d     = gnt1;
        byte_cnt_d = byte_cnt;
        timer_d    = timer;
        ifg_cnt_d  = ifg_cnt;
        phy_d      = '0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_WAIT_SOF;
                    owner_d = pick_idx;
                    gnt0_d  = ~pick_idx;
                    gnt1_d  = pick_idx;
                    timer_d = '0;
                end
            end

            ST_WAIT_SOF: begin
                if (own_en) begin
                    phy_d.en   = 1'b1;
                    phy_d.data = own_data;
                    byte_cnt_d = CNT_W'(1);
                    state_d    = ST_XMIT;
                end else if (!own_req || timer == TMR_W'(START_TIMEOUT - 1)) begin
                    // Nothing went out, so no gap is owed.
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    prio_d  = ~owner;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end

            ST_XMIT: begin
                if (!own_en) begin
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    prio_d    = ~owner;
                    ifg_cnt_d = '0;
                    state_d   = ST_IFG;
                end else if (byte_cnt == CNT_W'(MAX_LEN)) begin
                    // Oversize: poison the frame with one error byte and cut it.
                    phy_d.en   = 1'b1;
                    phy_d.er   = 1'b1;
                    phy_d.data = GMII_ERR_BYTE;
                    gnt0_d     = 1'b0;
                    gnt1_d     = 1'b0;
                    prio_d     = ~owner;
                    ifg_cnt_d  = '0;
                    state_d    = ST_IFG;
                end else begin
                    phy_d.en   = 1'b1;
                    phy_d.data = own_data;
                    if (byte_cnt != '1) begin
                        byte_cnt_d = byte_cnt + CNT_W'(1);
                    end
                end
            end

            ST_IFG: begin
                if (ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt + IFG_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            prio     <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            byte_cnt <= '0;
            timer    <= '0;
            ifg_cnt  <= '0;
            phy      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            prio     <= prio_d;
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            byte_cnt <= byte_cnt_d;
            timer    <= timer_d;
            ifg_cnt  <= ifg_cnt_d;
            phy      <= phy_d;
            busy     <= (state_d != ST_IDLE);
        end
    end

    assign phy_tx_en   = phy.en;
    assign phy_tx_er   = phy.er;
    assign phy_tx_data = phy.data;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Directed bench for ether_tx_arbiter: tie/round-robin, single frame, grant
// timeout, oversize truncation, eligibility and mid-frame reset.
module tb_ether_tx_arbiter;

    logic       clk_125 = 1'b0;
    logic       rst;
    logic       req0, tx0_en, req1, tx1_en;
    logic [7:0] tx0_data, tx1_data;
    logic       gnt0, gnt1, phy_tx_en, phy_tx_er, busy;
    logic [7:0] phy_tx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int both_hi = 0;

    ether_tx_arbiter dut (
        .clk_125     (clk_125),
        .rst         (rst),
        .req0        (req0),
        .gnt0        (gnt0),
        .tx0_en      (tx0_en),
        .tx0_data    (tx0_data),
        .req1        (req1),
        .gnt1        (gnt1),
        .tx1_en      (tx1_en),
        .tx1_data    (tx1_data),
        .phy_tx_en   (phy_tx_en),
        .phy_tx_er   (phy_tx_er),
        .phy_tx_data (phy_tx_data),
        .busy        (busy)
    );

    always #4 clk_125 = ~clk_125;

    always @(negedge clk_125) if (gnt0 && gnt1) both_hi++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    function automatic logic [7:0] fbyte(input int who, input int i);
        if (i < 7) return 8'h55;
        if (i == 7) return 8'hD5;
        return 8'(i * 3 + who * 8'h40);
    endfunction

    task automatic drive(input int who, input logic en, input logic [7:0] d);
        if (who == 0) begin tx0_en = en; tx0_data = d; end
        else          begin tx1_en = en; tx1_data = d; end
    endtask

    task automatic drop_req(input int who);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // Called on the first grant cycle; streams len bytes and checks the 1-cycle echo.
    task automatic run_frame(input int who, input int len);
        int bad = 0;
        for (int i = 0; i < len; i++) begin
            drive(who, 1'b1, fbyte(who, i));
            tick();
            if (phy_tx_en !== 1'b1 || phy_tx_er !== 1'b0 || phy_tx_data !== fbyte(who, i)) bad++;
            if ((who == 0 ? gnt0 : gnt1) !== 1'b1) bad++;
        end
        check("frame_bytes", 32'(bad), 32'd0);
        drive(who, 1'b0, 8'h00);
        drop_req(who);
        tick();
        check("eof_phy_en", 32'(phy_tx_en), 32'd0);
        check("eof_phy_data", 32'(phy_tx_data), 32'd0);
        check("eof_gnt", 32'(who == 0 ? gnt0 : gnt1), 32'd0);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 50) begin
            tick();
            guard++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int gap, cnt, hi;
        rst = 1'b1;
        req0 = 0; tx0_en = 0; tx0_data = 0;
        req1 = 0; tx1_en = 0; tx1_data = 0;
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_phy", {21'd0, phy_tx_en, phy_tx_er, phy_tx_data, busy}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Tie: requester 0 first, then 1 after a 14-cycle gap
        req0 = 1; req1 = 1;
        tick();
        check("tie_gnt0", 32'(gnt0), 32'd1);
        check("tie_gnt1", 32'(gnt1), 32'd0);
        run_frame(0, 60);
        req0 = 1;
        gap = 1; hi = 0; cnt = 0;
        while (!gnt1 && cnt < 30) begin
            tick();
            if (phy_tx_en) hi++;
            gap++; cnt++;
        end
        check("rr_gnt1", 32'(gnt1), 32'd1);
        check("rr_gnt0_low", 32'(gnt0), 32'd0);
        check("ifg_gap", 32'(gap), 32'd14);
        check("ifg_phy_quiet", 32'(hi), 32'd0);
        req0 = 0;
        run_frame(1, 60);
        wait_idle();
        req0 = 1; req1 = 1;
        tick();
        check("tie3_gnt0", 32'(gnt0), 32'd1);
        check("tie3_gnt1", 32'(gnt1), 32'd0);
        run_frame(0, 20);
        req1 = 0;
        wait_idle();

        // Single frame on 0 while 1 drives junk without requesting
        tx1_en = 1; tx1_data = 8'hEE;
        req0 = 1;
        tick();
        check("single_gnt0", 32'(gnt0), 32'd1);
        run_frame(0, 64);
        tx1_en = 0; tx1_data = 0;
        wait_idle();

        // Timeout: gnt1 unused for 64 cycles, pending req0 follows
        req1 = 1;
        tick();
        check("to_gnt1", 32'(gnt1), 32'd1);
        req0 = 1;
        cnt = 1; hi = 0; gap = 0;
        while (gnt1 && gap < 100) begin
            tick();
            if (gnt1) cnt++;
            if (phy_tx_en) hi++;
            gap++;
        end
        check("to_len", 32'(cnt), 32'd64);
        check("to_phy_quiet", 32'(hi), 32'd0);
        check("to_gnt0_not_yet", 32'(gnt0), 32'd0);
        req1 = 0;
        tick();
        check("to_gnt0_next", 32'(gnt0), 32'd1);
        req0 = 0;
        tick();
        wait_idle();

        // Oversize: 1526 good bytes, one error byte, then cut
        req0 = 1;
        tick();
        check("ovs_gnt0", 32'(gnt0), 32'd1);
        cnt = 0;
        for (int i = 0; i < 1526; i++) begin
            drive(0, 1'b1, 8'(i));
            tick();
            if (phy_tx_en !== 1'b1 || phy_tx_er !== 1'b0 || phy_tx_data !== 8'(i)) cnt++;
        end
        check("ovs_good_bytes", 32'(cnt), 32'd0);
        drive(0, 1'b1, 8'hAA);
        tick();
        check("ovs_err_cycle", {23'd0, phy_tx_en, phy_tx_er, phy_tx_data}, 32'h300);
        tick();
        check("ovs_cut_en", 32'(phy_tx_en), 32'd0);
        check("ovs_cut_gnt", 32'(gnt0), 32'd0);
        hi = 0;
        for (int i = 0; i < 472; i++) begin
            drive(0, 1'b1, 8'(i));
            tick();
            if (gnt0 || phy_tx_en) hi++;
        end
        check("ovs_no_regrant", 32'(hi), 32'd0);
        drive(0, 1'b0, 8'h00);
        tick();
        check("ovs_regrant", 32'(gnt0), 32'd1);
        req0 = 0;
        tick();
        wait_idle();

        // Eligibility: en already high blocks the grant
        tx1_en = 1; tx1_data = 8'h77; req1 = 1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt1) hi++;
        end
        check("elig_blocked", 32'(hi), 32'd0);
        tx1_en = 0; tx1_data = 0;
        tick();
        check("elig_gnt1", 32'(gnt1), 32'd1);
        req1 = 0;
        tick();
        wait_idle();

        // Reset at byte 30 clears outputs without waiting for a clock
        req0 = 1;
        tick();
        check("mid_gnt0", 32'(gnt0), 32'd1);
        for (int i = 0; i < 30; i++) begin
            drive(0, 1'b1, 8'(i + 1));
            tick();
        end
        check("mid_phy_live", 32'(phy_tx_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_phy", {21'd0, phy_tx_en, phy_tx_er, phy_tx_data, busy}, 32'd0);
        check("mid_rst_gnt0", 32'(gnt0), 32'd0);
        req0 = 0;
        drive(0, 1'b0, 8'h00);
        tick(); tick();
        rst = 1'b0;
        req1 = 1;
        tick();
        check("post_rst_gnt1", 32'(gnt1), 32'd1);
        check("post_rst_gnt0", 32'(gnt0), 32'd0);
        req1 = 0;
        tick();

        check("gnt_exclusive", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
